mem_perf_monitor: RTL and testbench
===================================

# mem_perf_monitor

Synthesizable, parametrised successor to the simulation-only cache statistics in the processor harness. Passively observes NUM_CH memory-side channels (e.g. icache proc port, dmem port) and counts requests, writes, misses, lower-level fetches and stall cycles in saturating counters. Counters are read back through a small memory-mapped register port. This lets firmware and benches obtain hit/miss figures without `real` arithmetic.

## Interface
- NUM_CH, 2, number of observed channels (1..8)
- CNT_WIDTH, 32, counter width in bits (8..32); reads zero-extend to 32
- BASE_ADDR, 32'h1000_1000, byte address of register window (must be 256 B aligned)

- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- mon_valid  in  NUM_CH  per-channel request valid
- mon_ready  in  NUM_CH  per-channel request ready
- mon_wr  in  NUM_CH  per-channel "request is a write" (wstrb nonzero)
- mon_miss  in  NUM_CH  per-channel cache miss flag; a rising edge is counted
- mon_lower_valid  in  NUM_CH  per-channel backing-memory valid; a rising edge is counted
- freeze  in  1  hold all counters (e.g. tied to trap)
- reg_valid  in  1  register access valid
- reg_ready  out  1  register access done
- reg_addr  in  32  register byte address
- reg_wdata  in  32  write data
- reg_wstrb  in  4  write strobes; 0 = read
- reg_rdata  out  32  read data, valid while reg_ready

## Operation
- Per channel c, five counters: REQ (valid&ready&~wr), WR (valid&ready&wr), MISS (miss rising edge), LOWER (lower_valid rising edge), STALL (valid&~ready cycles). One global CYCLE counter counts every cycle while enabled.
- Counters increment by 1 only when CTRL.EN=1 and freeze=0. They saturate at 2^CNT_WIDTH-1 and never wrap.
- Edge detectors keep a previous-value register that resets to 0. If an input is high on the first cycle after reset, that cycle counts as one edge.
- Register map:
  - Channel c block at BASE_ADDR + c*0x20 with offsets 0x00 REQ, 0x04 WR, 0x08 MISS, 0x0C LOWER, 0x10 STALL.
  - Global block at BASE_ADDR + NUM_CH*0x20 with offsets 0x00 CYCLE and 0x04 CTRL.
- CTRL bits:
  - bit0 EN (RW, reset 1).
  - bit1 CLR (write-1 pulse; zeroes all counters; reads 0).
  - bit2 FROZEN (RO, mirrors freeze).
- Writes to counters and to unmapped offsets are ignored. Reads of unmapped offsets inside the 256 B window return 0.
- Addresses outside the window are never claimed; reg_ready stays 0.
- Bus FSM has two states:
  - IDLE: on reg_valid with an in-window address, capture rdata and perform any write, then go to RESP.
  - RESP: drive reg_ready=1 for exactly one cycle, then return to IDLE.
- Priority within one cycle: CLR > freeze > increment. A cleared counter reads 0 next cycle even if its event fired that same cycle. CLR works while freeze=1.
- Reset mid-transaction: FSM returns to IDLE, reg_ready drops, all counters and edge registers clear, and EN is set to 1.

## Timing
- Reset values: reg_ready=0, reg_rdata=0, all counters 0, EN=1.
- An event in cycle N is visible in its counter after the posedge ending cycle N.
- Read latency is one cycle: valid accepted at edge E, then reg_ready=1 and reg_rdata stable during the cycle after E.
- reg_rdata returns the counter value before the update at edge E.
- The requester holds reg_valid and reg_addr until it sees reg_ready. The FSM cannot accept a new access in the RESP cycle, so back-to-back accesses complete at most one every 2 cycles.
- reg_rdata is 0 whenever reg_ready=0.
- A write to CTRL takes effect at the accept edge; counters see the new EN from the next cycle.

## Structure
- Package mem_perf_pkg holds:
  - register offset constants (OFF_REQ, OFF_WR, OFF_MISS, OFF_LOWER, OFF_STALL, OFF_CYCLE, OFF_CTRL);
  - CTRL bit indices;
  - a counter-index enum;
  - CH_STRIDE = 0x20.
- Sub-module perf_sat_cnt #(W) has inputs clk, resetn, clr, en, inc and output cnt. The top instantiates it 5*NUM_CH+1 times via generate.

## Test plan
- Reset, then 10 instruction reads on ch0 each with valid=ready for one cycle. Read REQ0 at BASE_ADDR+0x00: returns 10, reg_ready asserted one cycle after accept.
- ch1 holds valid with ready=0 for 7 cycles, then completes as a write. STALL1 (BASE+0x30) reads 7, WR1 (BASE+0x24) reads 1, REQ1 reads 0.
- mon_miss[0] held high for 5 cycles, low, then high for 1 cycle. MISS0 reads 2. mon_lower_valid[0] with 3 pulses gives LOWER0 = 3.
- CNT_WIDTH=8 with 300 REQ events on ch0: REQ0 reads 255. Write CTRL=0x2 (CLR) in the same cycle as an event: REQ0 reads 0.
- freeze=1 for 20 cycles of traffic: all counters unchanged and CTRL reads 0x5. Deassert freeze: counting resumes.
- Access to BASE_ADDR+0x100 (out of window): reg_ready stays 0. Unmapped in-window offset 0x1C: reads 0 with reg_ready after 1 cycle. Assert resetn=0 during RESP: reg_ready=0 next cycle and EN reads 1.

Source files
------------

// File: rtl/mem_perf_pkg.sv
// Shared constants and types for the memory performance monitor.
// Register offsets, CTRL bit indices, counter kinds and bus FSM states.
package mem_perf_pkg;

    // Offsets inside a per-channel block
    localparam logic [4:0] OFF_REQ   = 5'h00;
    localparam logic [4:0] OFF_WR    = 5'h04;
    localparam logic [4:0] OFF_MISS  = 5'h08;
    localparam logic [4:0] OFF_LOWER = 5'h0C;
    localparam logic [4:0] OFF_STALL = 5'h10;

    // Offsets inside the global block
    localparam logic [4:0] OFF_CYCLE = 5'h00;
    localparam logic [4:0] OFF_CTRL  = 5'h04;

    // CTRL register bits
    localparam int CTRL_EN     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_FROZEN = 2;

    localparam int unsigned CH_STRIDE = 32'h20;
    localparam int          NUM_KINDS = 5;

    typedef enum logic [2:0] {
        CI_REQ   = 3'd0,
        CI_WR    = 3'd1,
        CI_MISS  = 3'd2,
        CI_LOWER = 3'd3,
        CI_STALL = 3'd4,
        CI_NONE  = 3'd7
    } cnt_idx_e;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_e;

    // Map a channel-block offset to the counter it selects
    function automatic cnt_idx_e off_to_idx(input logic [4:0] off);
        cnt_idx_e idx;
        case (off)
            OFF_REQ:   idx = CI_REQ;
            OFF_WR:    idx = CI_WR;
            OFF_MISS:  idx = CI_MISS;
            OFF_LOWER: idx = CI_LOWER;
            OFF_STALL: idx = CI_STALL;
            default:   idx = CI_NONE;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mem_perf_monitor_cnt.sv
// Saturating event counter with synchronous clear.
// Ports: clk, resetn (sync, active-low), clr, en, inc -> cnt.
module perf_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over counting; count sticks at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_perf_monitor.sv
// Passive per-channel memory traffic counters with a register read port.
// Ports: clk/resetn, mon_* observed channels, freeze, reg_* register bus.
module mem_perf_monitor
    import mem_perf_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          CNT_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR = 32'h1000_1000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] mon_valid,
    input  logic [NUM_CH-1:0] mon_ready,
    input  logic [NUM_CH-1:0] mon_wr,
    input  logic [NUM_CH-1:0] mon_miss,
    input  logic [NUM_CH-1:0] mon_lower_valid,
    input  logic              freeze,
    input  logic              reg_valid,
    output logic              reg_ready,
    input  logic [31:0]       reg_addr,
    input  logic [31:0]       reg_wdata,
    input  logic [3:0]        reg_wstrb,
    output logic [31:0]       reg_rdata
);

    localparam int NCNT    = NUM_KINDS * NUM_CH + 1;
    localparam int CYC_IDX = NUM_KINDS * NUM_CH;

    // With eight channels the global block starts at 0x100, so the
    // decoded window grows to a second 256 B page to keep it reachable.
    localparam int unsigned GLB_OFF   = NUM_CH * CH_STRIDE;
    localparam int unsigned WIN_BYTES =
        (GLB_OFF + CH_STRIDE > 256) ? 512 : 256;

    // ---------------- event detection ----------------
    logic [NUM_CH-1:0] miss_prev_q;
    logic [NUM_CH-1:0] lower_prev_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            miss_prev_q  <= '0;
            lower_prev_q <= '0;
        end else begin
            miss_prev_q  <= mon_miss;
            lower_prev_q <= mon_lower_valid;
        end
    end

    logic [NUM_CH-1:0] ev_req;
    logic [NUM_CH-1:0] ev_wr;
    logic [NUM_CH-1:0] ev_miss;
    logic [NUM_CH-1:0] ev_lower;
    logic [NUM_CH-1:0] ev_stall;

    assign ev_req   = mon_valid & mon_ready & ~mon_wr;
    assign ev_wr    = mon_valid & mon_ready & mon_wr;
    assign ev_miss  = mon_miss & ~miss_prev_q;
    assign ev_lower = mon_lower_valid & ~lower_prev_q;
    assign ev_stall = mon_valid & ~mon_ready;

    // ---------------- counters ----------------
    logic                 en_q;
    logic                 en_d;
    logic                 clr_pulse;
    logic                 cnt_en;
    logic [NCNT-1:0]      inc;
    logic [CNT_WIDTH-1:0] cnt [NCNT];

    assign cnt_en = en_q & ~freeze;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign inc[NUM_KINDS*c + int'(CI_REQ)]   = ev_req[c];
        assign inc[NUM_KINDS*c + int'(CI_WR)]    = ev_wr[c];
        assign inc[NUM_KINDS*c + int'(CI_MISS)]  = ev_miss[c];
        assign inc[NUM_KINDS*c + int'(CI_LOWER)] = ev_lower[c];
        assign inc[NUM_KINDS*c + int'(CI_STALL)] = ev_stall[c];
    end

    assign inc[CYC_IDX] = 1'b1;

    for (genvar k = 0; k < NCNT; k++) begin : g_cnt
        perf_sat_cnt #(
            .W(CNT_WIDTH)
        ) u_cnt (
            .clk   (clk),
            .resetn(resetn),
            .clr   (clr_pulse),
            .en    (cnt_en),
            .inc   (inc[k]),
            .cnt   (cnt[k])
        );
    end

    // ---------------- address decode ----------------
    logic [31:0] rel;
    logic        in_win;
    logic [3:0]  blk;
    logic [4:0]  sub;
    logic        is_wr;
    logic        ctrl_hit;
    cnt_idx_e    kind;

    assign rel      = reg_addr - BASE_ADDR;
    assign in_win   = rel < 32'(WIN_BYTES);
    assign blk      = rel[8:5];
    assign sub      = rel[4:0];
    assign is_wr    = |reg_wstrb;
    assign ctrl_hit = (blk == 4'(NUM_CH)) && (sub == OFF_CTRL);
    assign kind     = off_to_idx(sub);

    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (blk == 4'(c) && kind != CI_NONE) begin
                rd_val = 32'(cnt[NUM_KINDS*c + int'(kind)]);
            end
        end
        if (blk == 4'(NUM_CH)) begin
            case (sub)
                OFF_CYCLE: rd_val = 32'(cnt[CYC_IDX]);
                OFF_CTRL: begin
                    rd_val[CTRL_EN]     = en_q;
                    rd_val[CTRL_FROZEN] = freeze;
                end
                default: rd_val = '0;
            endcase
        end
    end

    // ---------------- bus FSM ----------------
    bus_state_e  state_q;
    bus_state_e  state_d;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        en_d      = en_q;
        clr_pulse = 1'b0;
        reg_ready = 1'b0;
        unique case (state_q)
            BUS_IDLE: begin
                if (reg_valid && in_win) begin
                    state_d = BUS_RESP;
                    rdata_d = rd_val;
                    if (is_wr && ctrl_hit && reg_wstrb[0]) begin
                        en_d      = reg_wdata[CTRL_EN];
                        clr_pulse = reg_wdata[CTRL_CLR];
                    end
                end
            end
            BUS_RESP: begin
                reg_ready = 1'b1;
                state_d   = BUS_IDLE;
                // Drop read data so it is zero outside the response
                rdata_d   = '0;
            end
            default: begin
                state_d = BUS_IDLE;
                rdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= BUS_IDLE;
            rdata_q <= '0;
            en_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
        end
    end

    assign reg_rdata = rdata_q;

    logic unused_bits;
    assign unused_bits = ^{reg_wdata[31:2], rel[31:9]};

endmodule

// File: tb/tb_mem_perf_monitor.sv
// Scoreboard bench for mem_perf_monitor (2 channels, 8-bit counters).
// Expected read data is queued at issue and popped on reg_ready.
module tb_mem_perf_monitor;

    localparam logic [31:0] BASE = 32'h1000_1000;
    localparam logic [31:0] A_REQ0   = BASE + 32'h00;
    localparam logic [31:0] A_MISS0  = BASE + 32'h08;
    localparam logic [31:0] A_LOWER0 = BASE + 32'h0C;
    localparam logic [31:0] A_UNMAP  = BASE + 32'h1C;
    localparam logic [31:0] A_REQ1   = BASE + 32'h20;
    localparam logic [31:0] A_WR1    = BASE + 32'h24;
    localparam logic [31:0] A_MISS1  = BASE + 32'h28;
    localparam logic [31:0] A_STALL1 = BASE + 32'h30;
    localparam logic [31:0] A_CYCLE  = BASE + 32'h40;
    localparam logic [31:0] A_CTRL   = BASE + 32'h44;
    localparam logic [31:0] A_OOW    = BASE + 32'h100;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  mon_valid;
    logic [1:0]  mon_ready;
    logic [1:0]  mon_wr;
    logic [1:0]  mon_miss;
    logic [1:0]  mon_lower_valid;
    logic        freeze;
    logic        reg_valid;
    logic        reg_ready;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic [31:0] reg_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q [$];

    mem_perf_monitor #(
        .NUM_CH   (2),
        .CNT_WIDTH(8),
        .BASE_ADDR(BASE)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .mon_valid      (mon_valid),
        .mon_ready      (mon_ready),
        .mon_wr         (mon_wr),
        .mon_miss       (mon_miss),
        .mon_lower_valid(mon_lower_valid),
        .freeze         (freeze),
        .reg_valid      (reg_valid),
        .reg_ready      (reg_ready),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_wstrb      (reg_wstrb),
        .reg_rdata      (reg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive the monitored channels for n cycles, then one idle cycle
    task automatic mon(input logic [1:0] v, input logic [1:0] r,
                       input logic [1:0] w, input logic [1:0] m,
                       input logic [1:0] l, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mon_valid       = v;
            mon_ready       = r;
            mon_wr          = w;
            mon_miss        = m;
            mon_lower_valid = l;
        end
        @(negedge clk);
        mon_valid       = '0;
        mon_ready       = '0;
        mon_wr          = '0;
        mon_miss        = '0;
        mon_lower_valid = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr,
                            input logic [31:0] exp, input string tag);
        int waited;
        logic [31:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        reg_valid = 1'b1;
        reg_addr  = addr;
        reg_wstrb = 4'h0;
        reg_wdata = '0;
        @(negedge clk);
        waited = 0;
        while (!reg_ready && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_lat"}, 32'(waited), 32'd0);
        e = exp_q.pop_front();
        if (reg_ready) begin
            check(tag, reg_rdata, e);
        end else begin
            check({tag, "_rdy"}, 32'(reg_ready), 32'd1);
        end
        reg_valid = 1'b0;
        @(negedge clk);
        check({tag, "_rdy0"}, 32'(reg_ready), 32'd0);
        check({tag, "_rd0"}, reg_rdata, 32'd0);
    endtask

    // Optional pulse: one ch0 request in the same cycle as the accept
    task automatic bus_write(input logic [31:0] addr,
                             input logic [31:0] data,
                             input logic pulse, input string tag);
        int waited;
        @(negedge clk);
        reg_valid = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        reg_wstrb = 4'hF;
        if (pulse) begin
            mon_valid = 2'b01;
            mon_ready = 2'b01;
        end
        @(negedge clk);
        mon_valid = '0;
        mon_ready = '0;
        waited = 0;
        while (!reg_ready && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_lat"}, 32'(waited), 32'd0);
        reg_valid = 1'b0;
        reg_wstrb = 4'h0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        resetn          = 1'b0;
        mon_valid       = '0;
        mon_ready       = '0;
        mon_wr          = '0;
        mon_miss        = 2'b10;
        mon_lower_valid = '0;
        freeze          = 1'b0;
        reg_valid       = 1'b0;
        reg_addr        = '0;
        reg_wdata       = '0;
        reg_wstrb       = '0;

        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(reg_ready), 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        resetn = 1'b1;
        // miss[1] high right after reset: one edge
        repeat (3) @(negedge clk);
        mon_miss = '0;

        bus_read(A_CTRL, 32'h1, "ctrl_rst");
        bus_read(A_MISS1, 32'd1, "miss1_first");

        mon(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 10);
        bus_read(A_REQ0, 32'd10, "req0");

        mon(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 7);
        mon(2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 1);
        bus_read(A_STALL1, 32'd7, "stall1");
        bus_read(A_WR1, 32'd1, "wr1");
        bus_read(A_REQ1, 32'd0, "req1");

        mon(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 5);
        mon(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);
        bus_read(A_MISS0, 32'd2, "miss0");
        for (int i = 0; i < 3; i++) begin
            mon(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1);
        end
        bus_read(A_LOWER0, 32'd3, "lower0");

        @(negedge clk);
        freeze = 1'b1;
        mon(2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 20);
        bus_read(A_CTRL, 32'h5, "ctrl_frz");
        bus_read(A_REQ0, 32'd10, "req0_frz");
        freeze = 1'b0;
        mon(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 5);
        bus_read(A_REQ0, 32'd15, "req0_thaw");

        bus_write(A_CTRL, 32'h0, 1'b0, "en_off");
        mon(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 5);
        bus_read(A_CTRL, 32'h0, "ctrl_off");
        bus_read(A_REQ0, 32'd15, "req0_off");
        bus_write(A_CTRL, 32'h1, 1'b0, "en_on");

        mon(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 300);
        bus_read(A_REQ0, 32'd255, "req0_sat");
        bus_read(A_CYCLE, 32'd255, "cycle_sat");

        bus_write(A_CTRL, 32'h3, 1'b1, "clr");
        bus_read(A_REQ0, 32'd0, "req0_clr");
        bus_read(A_CTRL, 32'h1, "ctrl_clr");
        bus_read(A_STALL1, 32'd0, "stall1_clr");

        bus_write(A_REQ0, 32'hAA, 1'b0, "cnt_wr");
        bus_read(A_REQ0, 32'd0, "req0_ro");

        @(negedge clk);
        reg_valid = 1'b1;
        reg_addr  = A_OOW;
        reg_wstrb = 4'h0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (reg_ready) seen = 1'b1;
        end
        check("oow_rdy", 32'(seen), 32'd0);
        reg_valid = 1'b0;

        bus_read(A_UNMAP, 32'd0, "unmap");

        mon(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        bus_read(A_STALL1, 32'd3, "stall1_post");

        bus_write(A_CTRL, 32'h0, 1'b0, "en_off2");
        @(negedge clk);
        reg_valid = 1'b1;
        reg_addr  = A_CTRL;
        reg_wstrb = 4'h0;
        @(negedge clk);
        check("rst_resp_rdy", 32'(reg_ready), 32'd1);
        resetn    = 1'b0;
        reg_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_rdy", 32'(reg_ready), 32'd0);
        check("rst_mid_rdata", reg_rdata, 32'd0);
        resetn = 1'b1;
        bus_read(A_STALL1, 32'd0, "stall1_rst");
        bus_read(A_CTRL, 32'h1, "ctrl_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
